// File: rtl/tomo_count_ram.sv
// tomo_count_ram: histogram count RAM with a pipelined increment path, host read/write port and clear sweep.
// COUNT_SATURATE_EN: when defined, overflowing increments saturate instead of wrapping.
module tomo_count_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 13,
    parameter int INC_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    output logic              busy,
    input  logic              inc_valid,
    output logic              inc_ready,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic [INC_W-1:0]  inc_amt,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ovf
);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              s1_v, s2_v;
    logic [ADDR_W-1:0] s1_addr, s2_addr;
    logic [INC_W-1:0]  s1_amt;
    logic [DATA_W-1:0] s2_sum, rq;
    logic              run, inc_acc, rd_acc, clr_go, we;
    logic [ADDR_W-1:0] ra, wa;
    logic [DATA_W-1:0] wd, rd_fwd, base, sum_st;
    logic [DATA_W:0]   sum;

    assign run       = state == RUN;
    assign busy      = ~run;
    assign inc_ready = run & ~rd_en;
    assign wr_ready  = run & ~inc_valid & ~s1_v & ~s2_v;
    assign inc_acc   = inc_valid & inc_ready;
    assign rd_acc    = run & rd_en;
    assign clr_go    = run & clr_start;
    // Single write port shared by the clear sweep, increment writeback and host writes.
    assign we     = ~run | s2_v | (wr_en & wr_ready);
    assign wa     = ~run ? cnt : (s2_v ? s2_addr : wr_addr);
    assign wd     = ~run ? '0 : (s2_v ? s2_sum : wr_data);
    assign ra     = rd_en ? rd_addr : inc_addr;
    assign rd_fwd = (we && wa == ra) ? wd : mem[ra];
    // S1 sees the older increment still sitting in S2 for the same bin.
    assign base   = (s2_v && s2_addr == s1_addr) ? s2_sum : rq;
    assign sum    = {1'b0, base} + {{(DATA_W+1-INC_W){1'b0}}, s1_amt};
`ifdef COUNT_SATURATE_EN
    assign sum_st = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
    assign sum_st = sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (rd_acc | inc_acc) rq <= rd_fwd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CLEAR;
            cnt      <= '0;
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            ovf      <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= rd_fwd;
            s1_v    <= inc_acc & ~clr_go;
            s2_v    <= s1_v & run & ~clr_go;
            s1_addr <= inc_addr;
            s1_amt  <= inc_amt;
            s2_addr <= s1_addr;
            s2_sum  <= sum_st;
            if (clr_go) begin
                state <= CLEAR;
                cnt   <= '0;
                ovf   <= 1'b0;
            end else if (!run) begin
                cnt <= cnt + 1'b1;
                if (&cnt) state <= RUN;
            end else if (s1_v && sum[DATA_W]) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

// File: doc/tomo_count_ram.md
TOMO_COUNT_RAM -- requirements
Module: tomo_count_ram

Interface
REQ-001 Parameter DATA_W, 32, width of each count word.
REQ-002 Parameter ADDR_W, 13, address width; depth = 2^ADDR_W words (2*4^6 outcome/sign bins).
REQ-003 Parameter INC_W, 8, width of increment amount.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  synchronous, active-low reset.
REQ-006 Port clr_start  input  1  one-cycle pulse; request full-memory clear.
REQ-007 Port busy  output  1  high while clearing.
REQ-008 Port inc_valid  input  1  increment request valid.
REQ-009 Port inc_ready  output  1  increment request accepted when inc_valid & inc_ready.
REQ-010 Port inc_addr  input  ADDR_W  bin to increment.
REQ-011 Port inc_amt  input  INC_W  amount added, zero-extended.
REQ-012 Port rd_en  input  1  host read strobe.
REQ-013 Port rd_addr  input  ADDR_W  host read address.
REQ-014 Port rd_data  output  DATA_W  host read data.
REQ-015 Port rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-016 Port wr_en  input  1  host write strobe, honoured only when wr_ready=1.
REQ-017 Port wr_ready  output  1  host write accepted this cycle.
REQ-018 Port wr_addr  input  ADDR_W  host write address.
REQ-019 Port wr_data  input  DATA_W  host write data.
REQ-020 Port ovf  output  1  sticky flag, set when any increment exceeds 2^DATA_W-1.

Function
REQ-021 Storage SHALL be an inferred simple-dual-port RAM (one read port, one write port, registered read); no vendor IP instance.
REQ-022 FSM SHALL have states CLEAR and RUN; CLEAR writes 0 to addresses 0..2^ADDR_W-1, one per cycle, then enters RUN; clr_start in RUN enters CLEAR next cycle; clr_start in CLEAR is ignored.
REQ-023 busy SHALL be 1 exactly while in CLEAR; inc_ready, wr_ready SHALL be 0 and rd_en ignored (no rd_valid) in CLEAR.
REQ-024 Increment SHALL be a 3-stage pipeline: S0 accept and issue read, S1 read data returns, S2 sum written; RAM holds new value 3 cycles after acceptance.
REQ-025 Back-to-back increments to the same or different addresses SHALL be accepted every cycle; when inc_addr matches an in-flight S1/S2 address the pending sum SHALL be forwarded so no count is lost.
REQ-026 Host read SHALL have priority over increments on the read port: inc_ready = RUN & ~rd_en; rd_valid asserted exactly 1 cycle after rd_en, rd_data holds RAM content including any writeback committed in the same cycle (forwarded).
REQ-027 wr_ready SHALL be 1 only in RUN with no increment in S0..S2 and no inc_valid; host write commits next cycle.
REQ-028 Sum SHALL be computed in DATA_W+1 bits; carry-out sets ovf.
REQ-029 ovf SHALL be cleared only by reset or by entering CLEAR.
REQ-030 Entering CLEAR SHALL abort in-flight increments (no writeback after the transition cycle).

Reset
REQ-031 With rst_n=0 at a clock edge: busy=1, inc_ready=0, wr_ready=0, rd_valid=0, rd_data=0, ovf=0, pipeline emptied, clear counter=0, state=CLEAR.
REQ-032 After rst_n returns high, the clear sweep SHALL run to completion (2^ADDR_W cycles) before RUN; reset mid-sweep restarts at address 0.

Configuration
REQ-033 Macro COUNT_SATURATE_EN defined: on overflow the stored value SHALL be 2^DATA_W-1 (saturate), ovf set.
REQ-034 Macro COUNT_SATURATE_EN undefined: stored value SHALL wrap modulo 2^DATA_W, ovf set.

Verification
REQ-035 Reset release with ADDR_W=4 -> busy=1 for 16 cycles, then 0; reading all 16 addresses returns 0.
REQ-036 20 back-to-back increments of amt 1 to addr 5 -> read addr 5 returns 20; no inc_ready drop.
REQ-037 Alternating increments addr 2 amt 3 / addr 3 amt 7, 10 each, with rd_en pulses interleaved -> inc_ready low only on rd_en cycles; final reads 30 and 70.
REQ-038 Host write 0xFFFFFFFE to addr 9, then increment amt 3 -> ovf=1; read gives 0xFFFFFFFF with COUNT_SATURATE_EN, 0x00000001 without.
REQ-039 clr_start while 3 increments in flight -> busy next cycle, ovf=0, all addresses read 0 after sweep.
